fetch_next_pc_ctrl: RTL and testbench

Next-address generator and fetch sequencer feeding the 64-bit PC register's newAddrIn and consuming its addrOut, so it closes the fetch loop. Each cycle it selects sequential fetch, hold on hazard stall, or redirect on a branch resolved in MEM. It drives the pipeline flush strobes and a fetch-valid qualifier. It also keeps a sticky misalignment flag and stall/redirect event counters for debug.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_next_pc_ctrl_if.sv | 46 ++++
 rtl/fetch_next_pc_ctrl_sat_counter.sv | 24 ++
 rtl/fetch_next_pc_ctrl.sv | 95 +++++++++
 tb/tb_fetch_next_pc_ctrl.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and defaults for the fetch next-PC controller
// Contents:
//   fetch_state_e   sequencer state (BOOT after reset, RUN afterwards)
//   ADDR_W_DEF      default PC width (must match the PC register)
//   INSTR_BYTES_DEF default sequential fetch increment
//   RESET_PC_DEF    default first fetch address after reset
//   CNT_W_DEF       default debug event counter width
package fetch_pkg;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

  localparam int          ADDR_W_DEF      = 64;
  localparam int          INSTR_BYTES_DEF = 4;
  localparam logic [63:0] RESET_PC_DEF    = 64'h0;
  localparam int          CNT_W_DEF       = 32;

endpackage

// File: rtl/fetch_next_pc_ctrl_if.sv
// rtl/fetch_next_pc_ctrl_if.sv - fetch loop bundle between controller, PC register and pipeline
// Signals:
//   pc_current    PC register output (addrOut)
//   stall         load-use hold from the hazard unit
//   br_taken      branch/jump resolved taken in MEM
//   br_target     redirect address from MEM
//   next_pc       to PC register newAddrIn (combinational)
//   fetch_valid   instruction at pc_current is on the correct path (registered)
//   flush_*       IF/ID, ID/EX, EX/MEM squash strobes (combinational)
//   misalign_err  sticky: a taken branch had br_target[1:0] != 0
//   stall_cnt     saturating count of applied stall cycles
//   redirect_cnt  saturating count of redirects taken
// Modports:
//   master  controller side
//   slave   PC register / pipeline side
interface fetch_next_pc_ctrl_if #(
  parameter int ADDR_W = fetch_pkg::ADDR_W_DEF,
  parameter int CNT_W  = fetch_pkg::CNT_W_DEF
);

  logic [ADDR_W-1:0] pc_current;
  logic              stall;
  logic              br_taken;
  logic [ADDR_W-1:0] br_target;
  logic [ADDR_W-1:0] next_pc;
  logic              fetch_valid;
  logic              flush_if_id;
  logic              flush_id_ex;
  logic              flush_ex_mem;
  logic              misalign_err;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  redirect_cnt;

  modport master (
    input  pc_current, stall, br_taken, br_target,
    output next_pc, fetch_valid, flush_if_id, flush_id_ex, flush_ex_mem,
    output misalign_err, stall_cnt, redirect_cnt
  );

  modport slave (
    output pc_current, stall, br_taken, br_target,
    input  next_pc, fetch_valid, flush_if_id, flush_id_ex, flush_ex_mem,
    input  misalign_err, stall_cnt, redirect_cnt
  );

endinterface

// File: rtl/fetch_next_pc_ctrl_sat_counter.sv
// rtl/fetch_next_pc_ctrl_sat_counter.sv - saturating up-counter for debug events
// Ports:
//   clk    system clock, rising edge
//   clear  synchronous clear, wins over inc
//   inc    count one event this cycle
//   count  current value; holds at all-ones instead of wrapping
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/fetch_next_pc_ctrl.sv
// rtl/fetch_next_pc_ctrl.sv - next-PC generator and fetch sequencer closing the PC register loop
// Ports:
//   clk    system clock, rising edge
//   rst_n  synchronous active-low reset
//   bus    fetch_next_pc_ctrl_if.master (pc_current/stall/br_taken/br_target in;
//          next_pc, fetch_valid, flush strobes, misalign_err, counters out)
// next_pc and the flush strobes are combinational from the inputs and state;
// nothing depends on next_pc, so the only loop is through the external PC register.
module fetch_next_pc_ctrl
  import fetch_pkg::*;
#(
  parameter int                ADDR_W      = ADDR_W_DEF,
  parameter int                INSTR_BYTES = INSTR_BYTES_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC    = RESET_PC_DEF[ADDR_W-1:0],
  parameter int                CNT_W       = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fetch_next_pc_ctrl_if.master bus
);

  fetch_state_e      state;
  logic              fetch_valid_q;
  logic              misalign_q;
  logic              running;
  logic              redirect;
  logic              stall_applied;
  logic [ADDR_W-1:0] next_pc_c;

  // Reset is folded in so that a redirect in the same cycle as rst_n=0 does
  // not reach the PC register or the flush strobes.
  assign running       = rst_n && (state == RUN);
  assign redirect      = running && bus.br_taken;
  // Redirect beats stall, so a stall under a redirect is not counted.
  assign stall_applied = running && bus.stall && !bus.br_taken;

  always_comb begin
    next_pc_c = RESET_PC;
    if (redirect) begin
      next_pc_c = {bus.br_target[ADDR_W-1:2], 2'b00};
    end else if (stall_applied) begin
      next_pc_c = bus.pc_current;
    end else if (running) begin
      next_pc_c = bus.pc_current + ADDR_W'(INSTR_BYTES);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= BOOT;
      fetch_valid_q <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          state         <= RUN;
          fetch_valid_q <= 1'b1;
        end
        RUN: begin
          // The word fetched at the old pc_current is on the wrong path.
          fetch_valid_q <= !bus.br_taken;
          if (bus.br_taken && (bus.br_target[1:0] != 2'b00)) begin
            misalign_q <= 1'b1;
          end
        end
        default: begin
          state         <= BOOT;
          fetch_valid_q <= 1'b0;
        end
      endcase
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clear (!rst_n),
    .inc   (stall_applied),
    .count (bus.stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_redirect_cnt (
    .clk   (clk),
    .clear (!rst_n),
    .inc   (redirect),
    .count (bus.redirect_cnt)
  );

  assign bus.next_pc      = next_pc_c;
  assign bus.fetch_valid  = fetch_valid_q;
  assign bus.misalign_err = misalign_q;
  assign bus.flush_if_id  = redirect;
  assign bus.flush_id_ex  = redirect;
  assign bus.flush_ex_mem = redirect;

endmodule

// File: tb/tb_fetch_next_pc_ctrl.sv
// tb/tb_fetch_next_pc_ctrl.sv - scoreboard bench for fetch_next_pc_ctrl
module tb_fetch_next_pc_ctrl;

  localparam int          AW      = 64;
  localparam int          CW      = 8;
  localparam logic [63:0] RST_PC  = 64'h0;
  localparam int          CNT_MAX = (1 << CW) - 1;

  typedef struct {
    logic [63:0] next_pc;
    logic        fetch_valid;
    logic        flush;
    logic        misalign;
    int          stall_cnt;
    int          redirect_cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [63:0] pc_reg = 64'hFFFF_FFFF_FFFF_FFFC;

  fetch_next_pc_ctrl_if #(.ADDR_W(AW), .CNT_W(CW)) ifc ();

  fetch_next_pc_ctrl #(
    .ADDR_W(AW), .INSTR_BYTES(4), .RESET_PC(RST_PC), .CNT_W(CW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.master)
  );

  always #5 clk = ~clk;

  // External PC register closing the fetch loop.
  always @(posedge clk) pc_reg <= ifc.next_pc;
  assign ifc.pc_current = pc_reg;

  exp_t sbq[$];
  int   tests  = 0;
  int   failed = 0;

  // Reference model state, described in terms of the behaviour rules.
  bit          m_booted;
  bit          m_fv;
  bit          m_mis;
  int          m_sc;
  int          m_rc;
  logic [63:0] m_pc = 64'hFFFF_FFFF_FFFF_FFFC;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      chk("next_pc",      ifc.next_pc,                 e.next_pc);
      chk("fetch_valid",  64'(ifc.fetch_valid),        64'(e.fetch_valid));
      chk("flush_if_id",  64'(ifc.flush_if_id),        64'(e.flush));
      chk("flush_id_ex",  64'(ifc.flush_id_ex),        64'(e.flush));
      chk("flush_ex_mem", 64'(ifc.flush_ex_mem),       64'(e.flush));
      chk("misalign_err", 64'(ifc.misalign_err),       64'(e.misalign));
      chk("stall_cnt",    64'(ifc.stall_cnt),          64'(e.stall_cnt));
      chk("redirect_cnt", 64'(ifc.redirect_cnt),       64'(e.redirect_cnt));
    end
  end

  // One clock of stimulus: drive inputs, push expectation, advance model.
  task automatic cyc(input bit r, input bit s, input bit b, input logic [63:0] t);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n         = r;
    ifc.stall     = s;
    ifc.br_taken  = b;
    ifc.br_target = t;

    e.fetch_valid  = m_fv;
    e.misalign     = m_mis;
    e.stall_cnt    = m_sc;
    e.redirect_cnt = m_rc;
    e.flush        = 1'b0;
    if (!r || !m_booted) e.next_pc = RST_PC;
    else if (b) begin
      e.next_pc = t - (t % 4);
      e.flush   = 1'b1;
    end
    else if (s) e.next_pc = m_pc;
    else        e.next_pc = m_pc + 64'd4;
    sbq.push_back(e);

    if (!r) begin
      m_booted = 0; m_fv = 0; m_mis = 0; m_sc = 0; m_rc = 0;
    end else if (!m_booted) begin
      m_booted = 1; m_fv = 1;
    end else begin
      m_fv = !b;
      if (b) begin
        if (m_rc < CNT_MAX) m_rc++;
        if (t % 4 != 0) m_mis = 1;
      end else if (s) begin
        if (m_sc < CNT_MAX) m_sc++;
      end
    end
    m_pc = e.next_pc;
  endtask

  function automatic logic [63:0] rnd_target();
    logic [63:0] t;
    t = {$urandom, $urandom};
    if ($urandom_range(7) != 0) t[1:0] = 2'b00;
    if ($urandom_range(15) == 0) t = 64'hFFFF_FFFF_FFFF_FFF0 | (t & 64'hF);
    return t;
  endfunction

  initial begin
    rst_n         = 1'b0;
    ifc.stall     = 1'b0;
    ifc.br_taken  = 1'b0;
    ifc.br_target = '0;
    @(posedge clk);  // first reset edge; DUT state defined from here on

    cyc(0, 0, 0, 0);
    cyc(0, 1, 1, 64'h40);
    // Release: BOOT, then 4, 8, 12
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    // Hold at 0x20 for three stall cycles
    cyc(1, 0, 1, 64'h20);
    cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 0);
    cyc(1, 0, 0, 0);
    // Redirect beats stall
    cyc(1, 1, 1, 64'h100);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    // Misaligned target, then ten normal cycles
    cyc(1, 0, 1, 64'h102);
    for (int i = 0; i < 10; i++) cyc(1, 0, 0, 0);
    // Back-to-back redirects
    cyc(1, 0, 1, 64'h200);
    cyc(1, 0, 1, 64'h300);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    // Wrap from all-ones-minus-3 to zero
    cyc(1, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    // Reset in the same cycle as a redirect; BOOT then ignores a branch
    cyc(0, 1, 1, 64'h500);
    cyc(1, 1, 1, 64'h600);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);

    // Redirect-heavy random phase, enough to saturate redirect_cnt
    for (int i = 0; i < 400; i++)
      cyc(1, $urandom_range(1) == 1, $urandom_range(9) < 7, rnd_target());
    // Stall-heavy random phase, enough to saturate stall_cnt
    for (int i = 0; i < 600; i++)
      cyc(1, $urandom_range(9) < 6, $urandom_range(9) == 0, rnd_target());
    // Mixed phase with occasional resets
    for (int i = 0; i < 300; i++)
      cyc($urandom_range(49) != 0, $urandom_range(1) == 1, $urandom_range(3) == 0, rnd_target());

    @(negedge clk);
    #1;
    tests++;
    if (sbq.size() != 0) begin
      failed++;
      $display("FAIL drain: %0d expectations left, expected 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
